// File: rtl/psec5_spi_pkg.sv
// Shared definitions for the serial interface (PICO receiver and POCI readout).
package psec5_spi_pkg;

  // Readout FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } poci_state_t;

  // Default geometry of the register file and serial bytes
  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 16;

endpackage

// File: rtl/poci_readout.sv
// POCI readout transmitter: fetches the register addressed by PICO and shifts
// it out MSB-first; optional burst streams consecutive registers with wrap.
//
// Handshake: addr_valid is a one-cycle strobe with no back-pressure. Whenever it
// is sampled high, addr_in is taken as the new start address and any byte in
// flight is abandoned (a byte completing on that same edge still reports
// byte_done). The block never stalls the PICO side.
//
// NUM_REGS must not exceed 2**ADDR_W; the pointer arithmetic is done in ADDR_W bits.
module poci_readout
  import psec5_spi_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              burst_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              serial_out,
  output logic              busy,
  output logic              byte_done,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  poci_state_t       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              byte_done_q;

  logic [ADDR_W-1:0] ptr_d;
  logic              in_range_d;
  logic              last_bit_d;

  // Pointer advance with wrap only at the last legal register; range check for read-as-zero
  always_comb begin
    ptr_d      = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_ONE;
    in_range_d = ({1'b0, ptr_q} < REG_LIMIT);
    last_bit_d = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  end

  // Readout FSM with shift register, bit counter and address pointer
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
        end
        LOAD: begin
          shreg_q   <= in_range_d ? rd_data : '0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + CNT_ONE;
          if (last_bit_d) begin
            ptr_q       <= ptr_d;
            byte_done_q <= 1'b1;
            state_q     <= burst_en ? LOAD : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // A new address always wins over whatever was in progress
      if (addr_valid) begin
        ptr_q   <= addr_in;
        state_q <= LOAD;
      end
    end
  end

  // Outputs derived directly from registered state; line idles low outside SHIFT
  always_comb begin
    rd_addr    = ptr_q;
    serial_out = (state_q == SHIFT) ? shreg_q[DATA_W-1] : 1'b0;
    busy       = (state_q != IDLE);
    byte_done  = byte_done_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_poci_readout.sv
// Directed self-checking bench for poci_readout.
module tb_poci_readout;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // ---------------- clock / reset ----------------
  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       addr_valid = 1'b0;
  logic [7:0] addr_in = 8'h00;
  logic       burst_en = 1'b0;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       serial_out;
  logic       busy;
  logic       byte_done;
  logic [1:0] dbg_state;

  always #5 sclk = ~sclk;

  // Register file model: every address holds a value so out-of-range reads
  // would show nonzero data unless the DUT forces them to zero.
  logic [7:0] regs [256];
  assign rd_data = regs[rd_addr];

  poci_readout #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(16)) dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .addr_valid (addr_valid),
    .addr_in    (addr_in),
    .burst_en   (burst_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .serial_out (serial_out),
    .busy       (busy),
    .byte_done  (byte_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge, then settle 1 time unit so inputs/outputs are away from the edge
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Pulse addr_valid, check the LOAD cycle, stop at the first data bit
  task automatic start(input logic [7:0] addr, input logic burst);
    addr_valid = 1'b1;
    addr_in    = addr;
    burst_en   = burst;
    tick();
    addr_valid = 1'b0;
    check("load_state", dbg_state, ST_LOAD);
    check("load_busy", busy, 1'b1);
    check("load_ser", serial_out, 1'b0);
    check("load_addr", rd_addr, addr);
    tick();
  endtask

  // Check eight bits MSB-first from the expected queue; ends in the cycle after the last bit
  task automatic read_byte(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      check({tag, "_bit"}, serial_out, exp[7-i]);
      check({tag, "_nodone"}, byte_done, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'hE5;
    regs[1]  = 8'hAA;
    regs[2]  = 8'h5B;
    regs[3]  = 8'hC7;
    regs[4]  = 8'hFF;
    regs[15] = 8'h81;
    regs[0]  = 8'h3C;

    // Reset values
    #2;
    check("rst_ser", serial_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", byte_done, 1'b0);
    check("rst_addr", rd_addr, 8'h00);
    check("rst_state", dbg_state, ST_IDLE);
    tick();
    rstn = 1'b1;
    tick();
    check("idle_state", dbg_state, ST_IDLE);

    // Single read of reg 1 = 0xAA
    start(8'h01, 1'b0);
    exp_q.push_back(8'hAA);
    read_byte("single");
    check("single_done", byte_done, 1'b1);
    check("single_busy", busy, 1'b0);
    check("single_addr", rd_addr, 8'h02);
    tick();
    check("single_done_clr", byte_done, 1'b0);
    check("single_idle", dbg_state, ST_IDLE);

    // Burst from 15 with wrap to 0
    start(8'h0F, 1'b1);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h3C);
    read_byte("burst0");
    check("burst_done0", byte_done, 1'b1);
    check("burst_gap_ser", serial_out, 1'b0);
    check("burst_gap_busy", busy, 1'b1);
    check("burst_gap_state", dbg_state, ST_LOAD);
    check("burst_wrap_addr", rd_addr, 8'h00);
    burst_en = 1'b0;
    tick();
    read_byte("burst1");
    check("burst_done1", byte_done, 1'b1);
    check("burst_end_addr", rd_addr, 8'h01);
    check("burst_end_busy", busy, 1'b0);
    tick();

    // Out-of-range address reads as zero
    start(8'h20, 1'b0);
    exp_q.push_back(8'h00);
    read_byte("oor");
    check("oor_done", byte_done, 1'b1);
    check("oor_addr", rd_addr, 8'h21);
    tick();

    // Abort reg 1 after three bits with a new address 2
    start(8'h01, 1'b0);
    check("abort_b7", serial_out, 1'b1);
    tick();
    check("abort_b6", serial_out, 1'b0);
    tick();
    check("abort_b5", serial_out, 1'b1);
    tick();
    addr_valid = 1'b1;
    addr_in    = 8'h02;
    tick();
    addr_valid = 1'b0;
    check("abort_nodone", byte_done, 1'b0);
    check("abort_state", dbg_state, ST_LOAD);
    check("abort_ser", serial_out, 1'b0);
    check("abort_addr", rd_addr, 8'h02);
    tick();
    exp_q.push_back(8'h5B);
    read_byte("abort_new");
    check("abort_new_done", byte_done, 1'b1);
    check("abort_new_addr", rd_addr, 8'h03);
    tick();

    // Collision: new address on the last-bit edge of reg 1
    start(8'h01, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("coll_bit", serial_out, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
    end
    check("coll_bit0", serial_out, 1'b0);
    addr_valid = 1'b1;
    addr_in    = 8'h03;
    tick();
    addr_valid = 1'b0;
    check("coll_done", byte_done, 1'b1);
    check("coll_state", dbg_state, ST_LOAD);
    check("coll_addr", rd_addr, 8'h03);
    tick();
    exp_q.push_back(8'hC7);
    read_byte("coll_new");
    check("coll_new_done", byte_done, 1'b1);
    check("coll_new_addr", rd_addr, 8'h04);
    tick();

    // Reset mid-SHIFT in burst mode aborts immediately and does not resume
    start(8'h04, 1'b1);
    tick();
    tick();
    check("pre_rst_ser", serial_out, 1'b1);
    check("pre_rst_state", dbg_state, ST_SHIFT);
    rstn = 1'b0;
    #1;
    check("midrst_ser", serial_out, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", byte_done, 1'b0);
    check("midrst_addr", rd_addr, 8'h00);
    check("midrst_state", dbg_state, ST_IDLE);
    tick();
    rstn = 1'b1;
    burst_en = 1'b0;
    tick();
    check("postrst_state", dbg_state, ST_IDLE);
    tick();
    check("postrst_busy", busy, 1'b0);
    check("postrst_ser", serial_out, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
